// File: rtl/serial_rb_loader.sv
// serial_rb_loader: framed serial address+data receiver driving a register bank write strobe
module serial_rb_loader #(
   parameter int AW = 3,
   parameter int DW = 18,
   parameter int NPKT = 8,
   parameter int PARITY_EN = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sen,
   input  logic                      sd,
   output logic                      rb_rw,
   output logic [AW-1:0]             rb_a,
   output logic [DW-1:0]             rb_d,
   output logic                      done,
   output logic                      err_parity,
   output logic                      err_frame,
   output logic [$clog2(NPKT+1)-1:0] pkt_cnt
);
   localparam int W = AW + DW;
   localparam int CW = $clog2(W + 1);
   localparam int PW = $clog2(NPKT + 1);
   localparam logic [CW-1:0] A_LAST = CW'(AW - 1);
   localparam logic [CW-1:0] P_LAST = CW'(W - 1);
   localparam logic [PW-1:0] N_LAST = PW'(NPKT - 1);
   localparam logic [2:0] IDLE = 3'd0, ADDR = 3'd1, DATA = 3'd2, PAR = 3'd3, WRITE = 3'd4, ERR_P = 3'd5, DONE = 3'd6;

   logic [2:0]    state, nxt;
   logic [CW-1:0] bc;
   logic [W-1:0]  sh;
   logic          par;
   logic          shifting, in_frame;

   assign shifting = sen && (state == IDLE || state == ADDR || state == DATA);
   assign in_frame = state == ADDR || state == DATA || state == PAR;

   // next state: bit counter decides field boundaries, sen drop aborts a frame
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = !sen ? IDLE : AW == 1 ? DATA : ADDR;
         ADDR:    nxt = !sen ? IDLE : bc == A_LAST ? DATA : ADDR;
         DATA:    nxt = !sen ? IDLE : bc != P_LAST ? DATA : PARITY_EN != 0 ? PAR : WRITE;
         PAR:     nxt = !sen ? IDLE : (par ^ sd) ? ERR_P : WRITE;
         WRITE:   nxt = pkt_cnt == N_LAST ? DONE : IDLE;
         ERR_P:   nxt = IDLE;
         DONE:    nxt = DONE;
         default: nxt = IDLE;
      endcase
   end

   // state register plus internal shift register, bit counter and running parity
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bc    <= '0;
         sh    <= '0;
         par   <= 1'b0;
      end else begin
         state <= nxt;
         if (shifting) begin
            sh  <= {sh[W-2:0], sd};
            par <= (state != IDLE && par) ^ sd;
            bc  <= state == IDLE ? CW'(1) : bc + CW'(1);
         end
      end
   end

   // registered outputs: strobe and bank data only change on a completed packet
   always_ff @(posedge clk) begin
      if (rst) begin
         rb_rw      <= 1'b1;
         rb_a       <= '0;
         rb_d       <= '0;
         done       <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
         pkt_cnt    <= '0;
      end else begin
         rb_rw      <= state != WRITE;
         done       <= state == DONE;
         err_parity <= err_parity || state == ERR_P;
         err_frame  <= err_frame || (in_frame && !sen);
         if (state == WRITE) begin
            rb_a    <= sh[W-1:DW];
            rb_d    <= sh[DW-1:0];
            pkt_cnt <= pkt_cnt + PW'(1);
         end
      end
   end
endmodule

// File: tb/tb_serial_rb_loader.sv
// tb_serial_rb_loader: packet-level reference model checks for two serial_rb_loader configurations
module tb_serial_rb_loader;
   logic clk = 1'b0, rst = 1'b1;
   logic sen0 = 1'b0, sd0 = 1'b0, sen1 = 1'b0, sd1 = 1'b0;
   logic rb_rw0, done0, ep0, ef0;
   logic [2:0] rb_a0;
   logic [17:0] rb_d0;
   logic [3:0] cnt0;
   logic rb_rw1, done1, ep1, ef1;
   logic [3:0] rb_a1;
   logic [7:0] rb_d1;
   logic [1:0] cnt1;

   typedef struct {int u; int c; int a; int d;} wr_t;
   wr_t got[$], exp_q[$];
   int cyc = 0;
   int ncmp = 0, nfail = 0;
   int done_c[2] = '{-1, -1};
   int exp_done[2], m_cnt[2], m_a[2], m_d[2];
   logic m_ep[2], m_ef[2];

   serial_rb_loader dut0 (
      .clk(clk), .rst(rst), .sen(sen0), .sd(sd0), .rb_rw(rb_rw0), .rb_a(rb_a0), .rb_d(rb_d0),
      .done(done0), .err_parity(ep0), .err_frame(ef0), .pkt_cnt(cnt0));

   serial_rb_loader #(.AW(4), .DW(8), .NPKT(2), .PARITY_EN(0)) dut1 (
      .clk(clk), .rst(rst), .sen(sen1), .sd(sd1), .rb_rw(rb_rw1), .rb_a(rb_a1), .rb_d(rb_d1),
      .done(done1), .err_parity(ep1), .err_frame(ef1), .pkt_cnt(cnt1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rb_rw0 !== 1'b1) got.push_back(wr_t'{0, cyc, int'(rb_a0), int'(rb_d0)});
      if (rb_rw1 !== 1'b1) got.push_back(wr_t'{1, cyc, int'(rb_a1), int'(rb_d1)});
      if (done0 === 1'b1 && done_c[0] < 0) done_c[0] = cyc;
      if (done1 === 1'b1 && done_c[1] < 0) done_c[1] = cyc;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] g, logic [63:0] e);
      ncmp++;
      assert (g === e) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, g, e);
      end
   endtask

   task automatic send(int u, int a, int d, bit flip, int cut, int gap);
      int aw = u != 0 ? 4 : 3;
      int dw = u != 0 ? 8 : 18;
      int pe = u != 0 ? 0 : 1;
      int np = u != 0 ? 2 : 8;
      int l = aw + dw + pe;
      int n = cut > 0 ? cut : l;
      logic [63:0] pkt = (64'(a) << dw) | 64'(d);
      logic pbit = (^pkt) ^ flip;
      int start = cyc + 1;
      for (int i = 0; i < n; i++) begin
         logic b = i < aw + dw ? pkt[aw+dw-1-i] : pbit;
         if (u != 0) begin sen1 = 1'b1; sd1 = b; end
         else begin sen0 = 1'b1; sd0 = b; end
         tick();
      end
      sen0 = 1'b0; sen1 = 1'b0; sd0 = 1'b0; sd1 = 1'b0;
      repeat (gap) tick();
      if (m_cnt[u] < np) begin
         if (n < l) m_ef[u] = 1'b1;
         else if (pe == 1 && flip) m_ep[u] = 1'b1;
         else begin
            exp_q.push_back(wr_t'{u, start + l, a, d});
            m_a[u] = a;
            m_d[u] = d;
            m_cnt[u]++;
            if (m_cnt[u] == np) exp_done[u] = start + l + 1;
         end
      end
   endtask

   task automatic check(int u, string tag);
      repeat (3) tick();
      chk({tag, " nwr"}, got.size(), exp_q.size());
      while (got.size() > 0 && exp_q.size() > 0) begin
         wr_t g = got.pop_front();
         wr_t e = exp_q.pop_front();
         chk({tag, " wr_unit"}, g.u, e.u);
         chk({tag, " wr_cycle"}, g.c, e.c);
         chk({tag, " wr_addr"}, g.a, e.a);
         chk({tag, " wr_data"}, g.d, e.d);
      end
      got.delete();
      exp_q.delete();
      chk({tag, " err_parity"}, u != 0 ? ep1 : ep0, m_ep[u]);
      chk({tag, " err_frame"}, u != 0 ? ef1 : ef0, m_ef[u]);
      chk({tag, " pkt_cnt"}, u != 0 ? 64'(cnt1) : 64'(cnt0), m_cnt[u]);
      chk({tag, " rb_a"}, u != 0 ? 64'(rb_a1) : 64'(rb_a0), m_a[u]);
      chk({tag, " rb_d"}, u != 0 ? 64'(rb_d1) : 64'(rb_d0), m_d[u]);
      chk({tag, " rb_rw"}, u != 0 ? rb_rw1 : rb_rw0, 1'b1);
      chk({tag, " done"}, u != 0 ? done1 : done0, exp_done[u] >= 0);
      chk({tag, " done_cycle"}, done_c[u], exp_done[u]);
   endtask

   task automatic rcheck(int u, string tag);
      chk({tag, " rb_rw"}, u != 0 ? rb_rw1 : rb_rw0, 1'b1);
      chk({tag, " rb_a"}, u != 0 ? 64'(rb_a1) : 64'(rb_a0), 0);
      chk({tag, " rb_d"}, u != 0 ? 64'(rb_d1) : 64'(rb_d0), 0);
      chk({tag, " done"}, u != 0 ? done1 : done0, 1'b0);
      chk({tag, " err_parity"}, u != 0 ? ep1 : ep0, 1'b0);
      chk({tag, " err_frame"}, u != 0 ? ef1 : ef0, 1'b0);
      chk({tag, " pkt_cnt"}, u != 0 ? 64'(cnt1) : 64'(cnt0), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sen0 = 1'b0; sen1 = 1'b0; sd0 = 1'b0; sd1 = 1'b0;
      tick();
      tick();
      for (int u = 0; u < 2; u++) begin
         m_cnt[u] = 0; m_a[u] = 0; m_d[u] = 0;
         m_ep[u] = 1'b0; m_ef[u] = 1'b0;
         exp_done[u] = -1;
         done_c[u] = -1;
      end
      got.delete();
      exp_q.delete();
      rst = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rcheck(0, "reset0");
      rcheck(1, "reset1");
      do_reset();
      repeat (10) tick();
      check(0, "idle0");
      check(1, "idle1");

      send(0, 5, 'h2A5A3, 1'b0, 0, 1);
      check(0, "good_pkt");

      do_reset();
      send(0, 5, 'h2A5A3, 1'b1, 0, 1);
      send(0, 2, 'h00001, 1'b0, 0, 1);
      check(0, "parity_err");

      send(0, 4, 'h12345, 1'b0, 10, 1);
      send(0, 7, 'h3FFFF, 1'b0, 0, 1);
      check(0, "frame_err");

      do_reset();
      for (int i = 0; i < 14; i++) begin
         int cut = ($urandom % 6 == 0) ? $urandom_range(1, 20) : 0;
         send(0, $urandom_range(0, 7), $urandom_range(0, 'h3FFFF), $urandom % 4 == 0, cut, $urandom_range(1, 3));
      end
      check(0, "random");

      do_reset();
      for (int i = 0; i < 8; i++) send(0, i, i * 'h1111, 1'b0, 0, 1);
      send(0, 1, 'h00123, 1'b0, 0, 1);
      check(0, "eight_pkts");

      do_reset();
      send(0, 6, 'h01234, 1'b0, 0, 1);
      check(0, "pre_rst");
      for (int i = 0; i < 10; i++) begin
         sen0 = 1'b1;
         sd0 = 1'($urandom);
         tick();
      end
      rst = 1'b1;
      tick();
      rcheck(0, "mid_rst");
      do_reset();
      send(0, 3, 'h2BEEF, 1'b0, 0, 1);
      check(0, "post_rst");

      do_reset();
      send(1, 'hA, 'h5C, 1'b0, 0, 1);
      send(1, 'h3, 'hFF, 1'b0, 0, 1);
      check(1, "narrow");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
